// File: rtl/rs_pkg.sv
// rs_pkg: GF(8) constants, tables and helpers shared by the RS(7,5) decoder
package rs_pkg;

    localparam int N            = 7;
    localparam int K            = 5;
    localparam int SYMBOL_WIDTH = 3;
    localparam logic [3:0] PRIM_POLY = 4'b1011;

    // K message symbols followed by N-K parity symbols, packed low symbol first
    localparam int W = (K + (N - K)) * SYMBOL_WIDTH;

    typedef logic [SYMBOL_WIDTH-1:0] symbol_t;

    // alpha^e for e = 0..7 (alpha^7 wraps to alpha^0 so any 3-bit exponent is legal)
    localparam symbol_t ANTILOG [0:7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5, 3'd1};

    // log_alpha(s) for s = 0..7; zero has no logarithm and maps to 0
    localparam logic [2:0] LOG [0:7] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

    // Multiplicative inverse; 0 maps to 0 so callers never see X
    function automatic symbol_t gf_inv(symbol_t a);
        logic [2:0] e;
        e = (LOG[a] == 3'd0) ? 3'd0 : 3'd7 - LOG[a];
        return (a == '0) ? '0 : ANTILOG[e];
    endfunction

endpackage

// File: rtl/gf8_mul.sv
// gf8_mul: combinational GF(8) multiplier, shift-and-reduce over x^3+x+1
module gf8_mul
    import rs_pkg::*;
(
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] y
);

    logic [4:0] p;

    // carry-less product, then fold x^3 and x^4 back into the field
    always_comb begin
        p = {2'b00, a & {3{b[0]}}} ^ {1'b0, a & {3{b[1]}}, 1'b0} ^ {a & {3{b[2]}}, 2'b00};
        y = p[2:0] ^ (p[3] ? PRIM_POLY[2:0] : 3'd0) ^ (p[4] ? {PRIM_POLY[1:0], 1'b0} : 3'd0);
    end

endmodule

// File: rtl/rs_7_5_decoder.sv
// rs_7_5_decoder: single-symbol-correcting RS(7,5) decoder over GF(8), one-cycle latency
module rs_7_5_decoder
    import rs_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] codeword,
    output logic [W-1:0] corrected,
    output logic         out_valid,
    output logic         error_corrected,
    output logic         uncorrectable
);

    symbol_t    q1 [N];
    symbol_t    q2 [N];
    symbol_t    s1, s2, s1_sq, loc, mag;
    logic [2:0] j;
    logic       fix, bad;
    logic [W-1:0] next_word;

    for (genvar i = 0; i < N; i++) begin : g_syn
        gf8_mul u_s1 (.a(codeword[3*i +: 3]), .b(ANTILOG[i]),         .y(q1[i]));
        gf8_mul u_s2 (.a(codeword[3*i +: 3]), .b(ANTILOG[(2*i) % 7]), .y(q2[i]));
    end

    // S1 = r(alpha), S2 = r(alpha^2) as XOR of per-symbol terms
    always_comb begin
        s1 = '0;
        s2 = '0;
        for (int i = 0; i < N; i++) begin
            s1 = s1 ^ q1[i];
            s2 = s2 ^ q2[i];
        end
    end

    gf8_mul u_loc (.a(s2),    .b(gf_inv(s1)), .y(loc));
    gf8_mul u_sq  (.a(s1),    .b(s1),         .y(s1_sq));
    gf8_mul u_mag (.a(s1_sq), .b(gf_inv(s2)), .y(mag));

    // both syndromes nonzero -> fix symbol log(S2/S1); exactly one zero -> flag only
    always_comb begin
        j         = LOG[loc];
        fix       = (s1 != '0) && (s2 != '0);
        bad       = (s1 == '0) != (s2 == '0);
        next_word = fix ? codeword ^ ({{(W-3){1'b0}}, mag} << (3 * j)) : codeword;
    end

    // output register; payload only advances on a valid word
    always_ff @(posedge clk) begin
        if (reset) begin
            corrected       <= '0;
            out_valid       <= 1'b0;
            error_corrected <= 1'b0;
            uncorrectable   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                corrected       <= next_word;
                error_corrected <= fix;
                uncorrectable   <= bad;
            end
        end
    end

endmodule

// File: tb/tb_rs_7_5_decoder.sv
// tb_rs_7_5_decoder: directed self-checking bench for the RS(7,5) decoder
module tb_rs_7_5_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [20:0] codeword;
    logic [20:0] corrected;
    logic        out_valid;
    logic        error_corrected;
    logic        uncorrectable;

    int checks = 0;
    int passed = 0;

    localparam logic [20:0] GOOD = 21'o0163163;

    rs_7_5_decoder dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .codeword(codeword),
        .corrected(corrected),
        .out_valid(out_valid),
        .error_corrected(error_corrected),
        .uncorrectable(uncorrectable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [20:0] w, input logic ec, input logic unc);
        check({tag, ".word"}, 32'(corrected), 32'(w));
        check({tag, ".ec"}, 32'(error_corrected), 32'(ec));
        check({tag, ".unc"}, 32'(uncorrectable), 32'(unc));
        check({tag, ".ov"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        codeword = 21'o0133163;
        step();
        step();
        check("rst.word", 32'(corrected), 32'd0);
        check("rst.ov", 32'(out_valid), 32'd0);
        check("rst.ec", 32'(error_corrected), 32'd0);
        check("rst.unc", 32'(uncorrectable), 32'd0);

        reset = 1'b0;
        step();
        expect_out("post_rst", GOOD, 1'b1, 1'b0);

        in_valid = 1'b0;
        step();
        check("idle.ov", 32'(out_valid), 32'd0);
        check("idle.hold", 32'(corrected), 32'(GOOD));

        in_valid = 1'b1;
        codeword = GOOD;
        step();
        expect_out("clean", GOOD, 1'b0, 1'b0);

        codeword = 21'o0163162;
        step();
        expect_out("err_sym0", GOOD, 1'b1, 1'b0);

        codeword = 21'o0163171;
        step();
        expect_out("double", 21'o0163171, 1'b0, 1'b1);

        codeword = 21'h1FFFFF;
        step();
        expect_out("all_ones", 21'h1FFFFF, 1'b0, 1'b0);

        codeword = GOOD;
        step();
        expect_out("b2b0", GOOD, 1'b0, 1'b0);
        codeword = 21'o0133163;
        step();
        expect_out("b2b1", GOOD, 1'b1, 1'b0);
        codeword = 21'o0000000;
        step();
        expect_out("b2b2", 21'o0000000, 1'b0, 1'b0);

        for (int p = 0; p < 7; p++) begin
            for (int m = 1; m < 8; m++) begin
                codeword = GOOD ^ (21'(m) << (3 * p));
                step();
                check($sformatf("single_p%0d_m%0d.word", p, m), 32'(corrected), 32'(GOOD));
                check($sformatf("single_p%0d_m%0d.ec", p, m), 32'(error_corrected), 32'd1);
            end
        end

        codeword = 21'o0133163;
        reset    = 1'b1;
        step();
        check("mid_rst.ov", 32'(out_valid), 32'd0);
        check("mid_rst.word", 32'(corrected), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("after_rst.ov", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        step();
        expect_out("first_after_rst", GOOD, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rs_7_5_decoder.md
Name: rs_7_5_decoder

Overview:
Single-error-correcting Reed-Solomon RS(7,5) decoder over GF(2^3), for the RS(7,5) codec datapath. Each cycle it takes one 21-bit received codeword and computes syndromes S1 and S2. It corrects any single symbol error and returns the full corrected 7-symbol codeword, message and parity, registered with one-cycle latency. Uncorrectable patterns are flagged and passed through unchanged.

Parameters:
- N, 7: codeword length in symbols. Only the value 7 is supported.
- K, 5: message length in symbols. Only the value 5 is supported.
- SYMBOL_WIDTH, 3: bits per symbol. Only the value 3 is supported.

Ports:
- clk  in  1  system clock. All state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword is valid this cycle.
- codeword  in  N*SYMBOL_WIDTH (21)  received word. Symbol i is bits [3i+2:3i] and is the coefficient of x^i. Message is c6..c2 (bits 20:6); parity is c1,c0.
- corrected  out  21  corrected codeword, same packing as codeword.
- out_valid  out  1  corrected and flags are valid.
- error_corrected  out  1  a single symbol error was found and fixed.
- uncorrectable  out  1  detected error pattern that cannot be corrected.

Behaviour:
- Field arithmetic:
  - GF(8), primitive polynomial x^3+x+1, integer representation with MSB = x^2.
  - alpha = 3'b010.
  - Powers alpha^0..alpha^6 = 1,2,4,3,6,7,5.
  - Addition is XOR. Zero has no logarithm.
- Code: generator g(x) = (x+alpha)(x+alpha^2) = x^2 + 6x + 3.
- Syndromes:
  - S1 = r(alpha), S2 = r(alpha^2), where r is the received polynomial.
  - Computed combinationally from codeword.
- Decision, in this order:
  - S1=0 and S2=0: no error. Output = input; both flags 0.
  - S1!=0 and S2!=0:
    - Location alpha^j = S2/S1, with j in 0..6 taken from the log table.
    - Magnitude e = S1^2/S2.
    - Output = input with symbol j XOR e. error_corrected=1, uncorrectable=0.
    - Two-symbol errors that produce this pattern are miscorrected by design (bounded-distance decoder).
  - Exactly one of S1, S2 zero: output = input unchanged; uncorrectable=1, error_corrected=0.
- Timing:
  - Registered outputs, latency 1.
  - At rising edge k with reset=0: out_valid <= in_valid.
  - corrected and flags are loaded from the codeword present before edge k only when in_valid=1. Otherwise they hold their previous value.
  - Back-to-back words are accepted every cycle; no backpressure.
- Reset:
  - While reset=1 at a rising edge: corrected=0, out_valid=0, error_corrected=0, uncorrectable=0.
  - Reset overrides in_valid.
  - Reset during a stream discards the word in flight; the first valid output arrives one cycle after the first valid input following reset deassertion.
- No X-propagation: every output must be defined for any 21-bit input, including all-zero and all-ones.

Decomposition:
- Package rs_pkg holds:
  - constants N, K, SYMBOL_WIDTH, PRIM_POLY (4'b1011);
  - a symbol typedef (logic [2:0]);
  - antilog table (exponent -> symbol) and log table (symbol -> exponent);
  - function gf_inv.
- One sub-module, gf8_mul: purely combinational 3x3-bit GF(8) multiplier.
  - Shift-and-reduce or log/antilog based.
  - Returns 0 if either operand is 0.
  - Instantiated in the syndrome and magnitude logic.

Test Plan:
- Clean word: message c6..c2 = 0,1,6,3,1; codeword 21'o0163163 (c1=6, c0=3), in_valid=1 -> next cycle corrected=21'o0163163, error_corrected=0, uncorrectable=0, out_valid=1.
- Single error at symbol 4 (6->3): input 21'o0133163 -> S1=3, S2=1, j=4, e=5. Next cycle corrected=21'o0163163, error_corrected=1.
- Single error at symbol 0 (3->2): input 21'o0163162 -> corrected=21'o0163163, error_corrected=1. Repeat for every position 0..6 and every nonzero magnitude 1..7; all 49 must restore the word.
- Double error at symbols 1,0 (values 1 and 2): input 21'o0163171 -> S1=0, S2=6. Output 21'o0163171 unchanged, uncorrectable=1.
- Reset and idle:
  - reset=1 for 2 cycles while in_valid=1 with 21'o0133163 -> all outputs 0.
  - Release reset -> corrected=21'o0163163 one cycle later.
  - Then in_valid=0 -> out_valid=0 and corrected holds 21'o0163163.
- Back-to-back stream: 21'o0163163, 21'o0133163, 21'o0000000 on consecutive cycles -> outputs 21'o0163163, 21'o0163163, 21'o0000000 on the following consecutive cycles, error_corrected = 0, 1, 0.
